prga_decrypt: RTL
=================

PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 32, meaning the number of message bytes decrypted per run (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-005 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of run; feeds the downstream validity checker's sig_start.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 The block SHALL have ports s_addr (output, 8), s_wdata (output, 8), s_wren (output, 1), s_rdata (input, 8): S-array RAM, 256x8.
REQ-008 The block SHALL have ports rom_addr (output, 5) and rom_rdata (input, 8): encrypted-message ROM, 32x8.
REQ-009 The block SHALL have ports dec_addr (output, 5), dec_wdata (output, 8), dec_wren (output, 1): decrypted-message RAM, 32x8.

Function
REQ-010 The block SHALL treat all memories as synchronous, with read data valid two cycles after the address-setting state; each read therefore spans set-address, wait and capture states.
REQ-011 The block SHALL implement the states IDLE, SET_I, WAIT_I, CAP_I, SET_J, WAIT_J, CAP_J, WR_I, WR_J, SET_F, WAIT_F, CAP_F, WR_DEC, DONE.
REQ-012 In IDLE with start=1, the block SHALL clear i, j and k to 0 and go to SET_I; with start=0 it SHALL stay in IDLE.
REQ-013 In SET_I, the block SHALL compute i=(i+1) mod 256 and drive s_addr=i (new value); in CAP_I it SHALL capture si=s_rdata.
REQ-014 In SET_J, the block SHALL compute j=(j+si) mod 256 and drive s_addr=j (new value); in CAP_J it SHALL capture sj=s_rdata.
REQ-015 In WR_I, the block SHALL drive s_addr=i, s_wdata=sj, s_wren=1; in WR_J it SHALL drive s_addr=j, s_wdata=si, s_wren=1 (swap).
REQ-016 In SET_F, the block SHALL drive s_addr=(si+sj) mod 256 and rom_addr=k; in CAP_F it SHALL capture f=s_rdata and e=rom_rdata.
REQ-017 In WR_DEC, the block SHALL drive dec_addr=k, dec_wdata=f XOR e, dec_wren=1.
REQ-018 From WR_DEC, the block SHALL go to DONE if k==MSG_LEN-1, otherwise increment k and go to SET_I.
REQ-019 In DONE, the block SHALL assert done for exactly one cycle and then return to IDLE.
REQ-020 All index arithmetic SHALL be 8-bit modulo 256 (i, j and si+sj wrap 255->0 with carry discarded); k SHALL be 5 bits.
REQ-021 Each byte SHALL take exactly 12 cycles, so done goes high 12*MSG_LEN+1 cycles after the edge that sampled start (385 for MSG_LEN=32).
REQ-022 The block SHALL ignore start while busy=1; a start held high through DONE SHALL begin a new run from IDLE on the next sample.
REQ-023 s_wren and dec_wren SHALL be high only in WR_I/WR_J and WR_DEC respectively, and never simultaneously.
REQ-024 When i==j, WR_I and WR_J SHALL both write the same value to the same address, leaving S unchanged.
REQ-025 Outside their active states, address and data outputs are don't-care, but the write enables SHALL be 0.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, i=j=k=0, si=sj=f=e=0, done=0, busy=0, s_wren=0, dec_wren=0, and all address/data outputs to 0.
REQ-027 Reset asserted mid-run SHALL abort the run with no further writes; partially swapped S and partial decrypted RAM contents are left as-is, and done SHALL NOT pulse.

Verification
REQ-028 The bench SHALL cover: S[x]=x, rom[0]=0x55, start pulse -> WR_I/WR_J write S[1]=1, then dec[0]=0x57 (f=S[2]=0x02).
REQ-029 The bench SHALL cover: same setup, rom[1]=0x00 -> S[2]=3 and S[3]=2 after the swap, dec[1]=0x05.
REQ-030 The bench SHALL cover: MSG_LEN=32, start at edge 0 -> done high for exactly cycle 385 only, 32 dec writes at addresses 0..31 in order, busy low afterward.
REQ-031 The bench SHALL cover: start held high during a run -> no restart and no extra done; exactly one run per start accepted in IDLE.
REQ-032 The bench SHALL cover: reset_n low in cycle 100 of a run -> outputs zero asynchronously, no further writes, no done, and a fresh start afterward gives the same dec values as a clean run given the same initial S.
REQ-033 The bench SHALL cover: a reference model comparing all 32 dec bytes and the final S array against software RC4 PRGA for three random S permutations.

Source files
------------

// File: rtl/prga_decrypt.sv
// rtl/prga_decrypt.sv - RC4 PRGA keystream generator that decrypts a ROM message into RAM
module prga_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_rdata,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_rdata,
    output logic [4:0] dec_addr,
    output logic [7:0] dec_wdata,
    output logic       dec_wren
);

    typedef enum logic [3:0] {
        IDLE, SET_I, WAIT_I, CAP_I, SET_J, WAIT_J, CAP_J,
        WR_I, WR_J, SET_F, WAIT_F, CAP_F, WR_DEC, DONE
    } state_t;

    localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

    state_t     r_state;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [4:0] r_k;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_f;
    logic [7:0] r_e;

    logic       r_done;
    logic       r_busy;
    logic [7:0] r_s_addr;
    logic [7:0] r_s_wdata;
    logic       r_s_wren;
    logic [4:0] r_rom_addr;
    logic [4:0] r_dec_addr;
    logic [7:0] r_dec_wdata;
    logic       r_dec_wren;

    logic [7:0] w_j_new;
    logic [7:0] w_i_new;
    logic [7:0] w_f_idx;

    assign w_j_new = r_j + s_rdata;
    assign w_i_new = r_i + 8'd1;
    assign w_f_idx = r_si + r_sj;

    // Outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_k         <= 5'd0;
            r_si        <= 8'd0;
            r_sj        <= 8'd0;
            r_f         <= 8'd0;
            r_e         <= 8'd0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_s_addr    <= 8'd0;
            r_s_wdata   <= 8'd0;
            r_s_wren    <= 1'b0;
            r_rom_addr  <= 5'd0;
            r_dec_addr  <= 5'd0;
            r_dec_wdata <= 8'd0;
            r_dec_wren  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_s_wren   <= 1'b0;
            r_dec_wren <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // i is cleared and pre-incremented in one step for the first SET_I
                        r_i      <= 8'd1;
                        r_j      <= 8'd0;
                        r_k      <= 5'd0;
                        r_s_addr <= 8'd1;
                        r_busy   <= 1'b1;
                        r_state  <= SET_I;
                    end
                end
                SET_I:  r_state <= WAIT_I;
                WAIT_I: r_state <= CAP_I;
                CAP_I: begin
                    r_si     <= s_rdata;
                    r_j      <= w_j_new;
                    r_s_addr <= w_j_new;
                    r_state  <= SET_J;
                end
                SET_J:  r_state <= WAIT_J;
                WAIT_J: r_state <= CAP_J;
                CAP_J: begin
                    r_sj      <= s_rdata;
                    r_s_addr  <= r_i;
                    r_s_wdata <= s_rdata;
                    r_s_wren  <= 1'b1;
                    r_state   <= WR_I;
                end
                WR_I: begin
                    r_s_addr  <= r_j;
                    r_s_wdata <= r_si;
                    r_s_wren  <= 1'b1;
                    r_state   <= WR_J;
                end
                WR_J: begin
                    r_s_addr   <= w_f_idx;
                    r_rom_addr <= r_k;
                    r_state    <= SET_F;
                end
                SET_F:  r_state <= WAIT_F;
                WAIT_F: r_state <= CAP_F;
                CAP_F: begin
                    r_f         <= s_rdata;
                    r_e         <= rom_rdata;
                    r_dec_addr  <= r_k;
                    r_dec_wdata <= s_rdata ^ rom_rdata;
                    r_dec_wren  <= 1'b1;
                    r_state     <= WR_DEC;
                end
                WR_DEC: begin
                    if (r_k == LAST_K) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k      <= r_k + 5'd1;
                        r_i      <= w_i_new;
                        r_s_addr <= w_i_new;
                        r_state  <= SET_I;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign busy      = r_busy;
    assign s_addr    = r_s_addr;
    assign s_wdata   = r_s_wdata;
    assign s_wren    = r_s_wren;
    assign rom_addr  = r_rom_addr;
    assign dec_addr  = r_dec_addr;
    assign dec_wdata = r_dec_wdata;
    assign dec_wren  = r_dec_wren;

endmodule
